// File: rtl/dsm_multibit.sv
// dsm_multibit: second-order multi-level delta-sigma modulator.
//
// Turns a signed PCM sample stream into a signed code stream in the range -QL..+QL
// (QL = 2**QL_LOG2), intended to drive a PWM/DAC output stage. Two cascaded
// integrators are noise-shaped by a clamped uniform quantizer. Optional LFSR dither
// is added just ahead of the quantizer. Both integrators saturate rather than wrap.
// A run of saturated samples triggers a one-sample recovery that empties the
// integrators and raises a sticky overload flag. Mute forces silence and holds
// both integrators at zero.
//
// Ports:
//   clock     in   sole clock, rising edge
//   reset     in   asynchronous active-high reset
//   vin       in   signed input sample, IN_W bits
//   in_valid  in   vin is accepted on cycles where this is 1; all state holds otherwise
//   dith_en   in   1 = add LFSR dither ahead of the quantizer
//   mute      in   1 = output silence and hold the integrators at zero
//   clr_ovl   in   clears the sticky overload flag on the next edge
//   out_code  out  signed quantizer code, registered, one cycle after acceptance
//   out_valid out  one-cycle pulse per accepted sample
//   overload  out  sticky overload flag

module dsm_multibit #(
    parameter int unsigned IN_W      = 16,
    parameter int unsigned QL_LOG2   = 1,
    parameter int unsigned ACC_W     = 20,
    parameter int unsigned DITH_W    = 4,
    parameter int unsigned OVL_LIMIT = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [IN_W-1:0]    vin,
    input  logic               in_valid,
    input  logic               dith_en,
    input  logic               mute,
    input  logic               clr_ovl,
    output logic [QL_LOG2+1:0] out_code,
    output logic               out_valid,
    output logic               overload
);

    // Two guard bits over the integrator width so no intermediate sum can wrap.
    localparam int unsigned SUM_W  = ACC_W + 2;
    localparam int unsigned CODE_W = QL_LOG2 + 2;
    // log2 of the quantizer step: step = 2**(IN_W-1-QL_LOG2).
    localparam int unsigned SHIFT  = IN_W - 1 - QL_LOG2;
    localparam int unsigned CNT_W  = $clog2(OVL_LIMIT + 1);

    localparam logic signed [SUM_W-1:0] HALF_STEP = SUM_W'(1) << (SHIFT - 1);
    localparam logic signed [SUM_W-1:0] QL_POS    = SUM_W'(1) << QL_LOG2;
    localparam logic signed [SUM_W-1:0] QL_NEG    = -QL_POS;
    // Symmetric saturation range: +/-(2**(ACC_W-1) - 1).
    localparam logic signed [SUM_W-1:0] ACC_MAX   = (SUM_W'(1) << (ACC_W - 1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] ACC_MIN   = -ACC_MAX;

    typedef enum logic [1:0] {
        StRun,
        StRecover,
        StMute
    } state_e;

    state_e                   state_q;
    logic signed [ACC_W-1:0]  i1_q;
    logic signed [ACC_W-1:0]  i2_q;
    logic [15:0]              lfsr_q;
    logic [CNT_W-1:0]         sat_cnt_q;

    logic signed [SUM_W-1:0]  dith;
    logic signed [SUM_W-1:0]  s_biased;
    logic signed [SUM_W-1:0]  q_shift;
    logic signed [SUM_W-1:0]  q_wide;
    logic signed [CODE_W-1:0] q;
    logic signed [SUM_W-1:0]  fb;
    logic signed [SUM_W-1:0]  i1_sum;
    logic signed [SUM_W-1:0]  i2_sum;
    logic                     i1_ovf;
    logic                     i2_ovf;
    logic                     any_ovf;
    logic [15:0]              lfsr_next;
    logic [CNT_W-1:0]         cnt_inc;
    logic                     cnt_hit;

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] x);
        if (x > ACC_MAX) begin
            return ACC_W'(ACC_MAX);
        end else if (x < ACC_MIN) begin
            return ACC_W'(ACC_MIN);
        end
        return ACC_W'(x);
    endfunction

    // Quantizer and loop sums, all from the current register state.
    always_comb begin
        dith = '0;
        if (dith_en) begin
            dith = SUM_W'($signed(lfsr_q[DITH_W-1:0]));
        end

        // Round to nearest by biasing half a step, then floor via arithmetic shift.
        s_biased = SUM_W'(i2_q) + dith + HALF_STEP;
        q_shift  = s_biased >>> SHIFT;

        if (q_shift > QL_POS) begin
            q_wide = QL_POS;
        end else if (q_shift < QL_NEG) begin
            q_wide = QL_NEG;
        end else begin
            q_wide = q_shift;
        end
        q  = CODE_W'(q_wide);
        fb = q_wide <<< SHIFT;

        // The second integrator consumes the old i1 and twice the feedback.
        i1_sum = SUM_W'(i1_q) + SUM_W'($signed(vin)) - fb;
        i2_sum = SUM_W'(i2_q) + SUM_W'(i1_q) - (fb <<< 1);

        i1_ovf  = (i1_sum > ACC_MAX) || (i1_sum < ACC_MIN);
        i2_ovf  = (i2_sum > ACC_MAX) || (i2_sum < ACC_MIN);
        any_ovf = i1_ovf || i2_ovf;
    end

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1 in right-shifting form.
    always_comb begin
        lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // Consecutive-saturation counter; pins at the limit so it cannot roll over.
    always_comb begin
        cnt_inc = sat_cnt_q;
        if (sat_cnt_q != CNT_W'(OVL_LIMIT)) begin
            cnt_inc = sat_cnt_q + CNT_W'(1);
        end
        cnt_hit = (cnt_inc == CNT_W'(OVL_LIMIT));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StRun;
            i1_q      <= '0;
            i2_q      <= '0;
            lfsr_q    <= 16'hACE1;
            sat_cnt_q <= '0;
            out_code  <= '0;
            out_valid <= 1'b0;
            overload  <= 1'b0;
        end else begin
            out_valid <= in_valid;

            // Clear first so a set later in this block wins on the same edge.
            if (clr_ovl) begin
                overload <= 1'b0;
            end

            if (in_valid) begin
                if (dith_en) begin
                    lfsr_q <= lfsr_next;
                end

                if (mute) begin
                    // Mute overrides everything, from any state.
                    state_q   <= StMute;
                    i1_q      <= '0;
                    i2_q      <= '0;
                    sat_cnt_q <= '0;
                    out_code  <= '0;
                end else begin
                    case (state_q)
                        StRecover: begin
                            state_q   <= StRun;
                            i1_q      <= '0;
                            i2_q      <= '0;
                            sat_cnt_q <= '0;
                            out_code  <= '0;
                        end
                        default: begin
                            // StRun, or StMute being released: in StMute both integrators
                            // are already zero, so this sample is a clean fresh start.
                            i1_q     <= sat(i1_sum);
                            i2_q     <= sat(i2_sum);
                            out_code <= q;
                            state_q  <= StRun;
                            if (any_ovf) begin
                                sat_cnt_q <= cnt_inc;
                                if (cnt_hit) begin
                                    state_q  <= StRecover;
                                    overload <= 1'b1;
                                end
                            end else begin
                                sat_cnt_q <= '0;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule
